// File: rtl/dmem_responder_if.sv
// Load/store request channel between the core (master) and a data-memory responder (slave).
interface dmem_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;
   logic        err;
   logic        busy;

   modport master (output req, we, addr, wdata, input ack, rdata, err, busy);
   modport slave  (input req, we, addr, wdata, output ack, rdata, err, busy);
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: latches one request, inserts WAIT_CYCLES
// wait states, then acks with read data / error and commits aligned stores.
// Optional access counters (rd_count/wr_count) are built when DMEM_STATS_EN is defined.
module dmem_responder #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic           clk,
   input  logic           rst,
   dmem_responder_if.slave bus
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0]    rd_count,
   output logic [15:0]    wr_count
`endif
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned LAT_W = ADDR_W + 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state;
   state_t            state_d;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_d;

   logic              we_q;
   logic [LAT_W-1:0]  addr_q;
   logic [31:0]       wdata_q;

   logic              ack_q;
   logic              busy_q;
   logic              err_q;
   logic [31:0]       rdata_q;
   logic              ack_d;
   logic              busy_d;
   logic              err_d;
   logic [31:0]       rdata_d;

   logic              latch_en;
   logic              mem_wr;
   logic              mis_q;

   logic              cur_we;
   logic [LAT_W-1:0]  cur_addr;
   logic              cur_mis;
   logic [ADDR_W-1:0] cur_idx;

   logic [31:0]       mem [DEPTH];

   logic              unused_addr_hi;

   // Address bits above the word index are deliberately ignored (wrap modulo DEPTH).
   assign unused_addr_hi = ^bus.addr[31:LAT_W];

   // With zero wait states RESP is entered on the sampling edge, so use live inputs in IDLE.
   assign cur_we   = (state == S_IDLE) ? bus.we : we_q;
   assign cur_addr = (state == S_IDLE) ? bus.addr[LAT_W-1:0] : addr_q;
   assign cur_mis  = (cur_addr[1:0] != 2'b00);
   assign cur_idx  = cur_addr[LAT_W-1:2];
   assign mis_q    = (addr_q[1:0] != 2'b00);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next-state, wait counter and response values.
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      latch_en = 1'b0;
      mem_wr   = 1'b0;
      ack_d    = 1'b0;
      err_d    = err_q;
      rdata_d  = rdata_q;

      case (state)
         S_IDLE: begin
            if (bus.req) begin
               latch_en = 1'b1;
               cnt_d    = CNT_W'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            mem_wr  = we_q & ~mis_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if ((state_d == S_RESP) && (state != S_RESP)) begin
         ack_d = 1'b1;
         if (cur_mis) begin
            err_d   = 1'b1;
            rdata_d = 32'd0;
         end else begin
            err_d = 1'b0;
            if (!cur_we) begin
               rdata_d = mem[cur_idx];
            end
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   // Registered outputs and wait counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         cnt     <= cnt_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Request capture; inputs are ignored once the access is in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
      end else if (latch_en) begin
         we_q    <= bus.we;
         addr_q  <= bus.addr[LAT_W-1:0];
         wdata_q <= bus.wdata;
      end
   end

   // Storage array, not cleared by reset; aligned stores commit on the edge leaving RESP.
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem[addr_q[LAT_W-1:2]] <= wdata_q;
      end
   end

   assign bus.ack   = ack_q;
   assign bus.busy  = busy_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;

`ifdef DMEM_STATS_EN
   // Saturating counters of completed aligned loads and stores.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_count <= 16'd0;
         wr_count <= 16'd0;
      end else if ((state == S_RESP) && !mis_q) begin
         if (we_q) begin
            if (wr_count != 16'hFFFF) begin
               wr_count <= wr_count + 16'd1;
            end
         end else begin
            if (rd_count != 16'hFFFF) begin
               rd_count <= rd_count + 16'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (main instance WAIT_CYCLES=2, second instance WAIT_CYCLES=0).
module tb_dmem_responder;
   localparam int unsigned DEPTH  = 256;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned WAITS  = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dmem_responder_if bus();
   dmem_responder_if bus0();

`ifdef DMEM_STATS_EN
   logic [15:0] rd_count, wr_count, rd_count0, wr_count0;
`endif

   dmem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAITS)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef DMEM_STATS_EN
      , .rd_count(rd_count), .wr_count(wr_count)
`endif
   );

   dmem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk),
      .rst(rst),
      .bus(bus0)
`ifdef DMEM_STATS_EN
      , .rd_count(rd_count0), .wr_count(wr_count0)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: word array plus counts of completed aligned accesses.
   logic [31:0] ref_mem [DEPTH];
   int          exp_rd = 0;
   int          exp_wr = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int word_of(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   task automatic model_apply(input logic w, input logic [31:0] a, input logic [31:0] d);
      if ((a % 4) == 0) begin
         if (w) begin
            ref_mem[word_of(a)] = d;
            if (exp_wr < 65535) exp_wr++;
         end else begin
            if (exp_rd < 65535) exp_rd++;
         end
      end
   endtask

   // One access on the main instance; called just after a rising edge with the DUT idle.
   task automatic run_and_check(input string name, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic exp_err,
                                input logic [31:0] exp_rdata);
      logic got;
      got = 1'b0;
      bus.req   = 1'b1;
      bus.we    = w;
      bus.addr  = a;
      bus.wdata = d;
      for (int n = 1; n <= int'(WAITS) + 4 && !got; n++) begin
         @(posedge clk); #1;
         if (bus.ack) begin
            got = 1'b1;
            check({name, "_latency"}, 32'(n), 32'(WAITS + 1));
            check({name, "_err"}, 32'(bus.err), 32'(exp_err));
            if (!w) check({name, "_rdata"}, bus.rdata, exp_rdata);
            bus.req = 1'b0;
         end else begin
            check({name, "_busy_wait"}, 32'(bus.busy), 32'd1);
            bus.we    = 1'($urandom_range(0, 1));
            bus.addr  = $urandom;
            bus.wdata = $urandom;
         end
      end
      bus.req = 1'b0;
      if (!got) check({name, "_ack_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
      check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
      check({name, "_idle_ack"}, 32'(bus.ack), 32'd0);
      model_apply(w, a, d);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic        w;
      logic [31:0] a, d, er, hi;
      int          idx, lo;

      vecs[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
      vecs[1] = '{1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 32'h13,  32'h0,        1'b1, 32'h0};
      vecs[3] = '{1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
      vecs[4] = '{1'b1, 32'h410, 32'h1234,     1'b0, 32'h0};
      vecs[5] = '{1'b0, 32'h10,  32'h0,        1'b0, 32'h00001234};
      vecs[6] = '{1'b1, 32'h22,  32'h5555,     1'b1, 32'h0};
      vecs[7] = '{1'b0, 32'h20,  32'h0,        1'b0, 32'hC0DE0008};
      vecs[8] = '{1'b0, 32'hFFC, 32'h0,        1'b0, 32'hC0DE00FF};

      bus.req = 1'b0;  bus.we = 1'b0;  bus.addr = '0;  bus.wdata = '0;
      bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;

      // Reset state.
      #1;
      check("rst_ack",   32'(bus.ack),  32'd0);
      check("rst_busy",  32'(bus.busy), 32'd0);
      check("rst_err",   32'(bus.err),  32'd0);
      check("rst_rdata", bus.rdata,     32'd0);
      check("rst0_ack",  32'(bus0.ack), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // Fill every word with a known pattern.
      for (int i = 0; i < int'(DEPTH); i++) begin
         run_and_check("init", 1'b1, 32'(i * 4), 32'hC0DE0000 | 32'(i), 1'b0, 32'h0);
      end

      // Directed table.
      for (int i = 0; i < 9; i++) begin
         run_and_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                       vecs[i].exp_err, vecs[i].exp_rdata);
      end

      // Reset during the wait phase of a store aborts it.
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h20; bus.wdata = 32'hAAAA5555;
      @(posedge clk); #1;
      check("abort_busy_before", 32'(bus.busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_ack",  32'(bus.ack),  32'd0);
      check("abort_err",  32'(bus.err),  32'd0);
      bus.req = 1'b0;
      exp_rd = 0;
      exp_wr = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_and_check("abort_reload", 1'b0, 32'h20, 32'h0, 1'b0, 32'hC0DE0008);

      // Randomized accesses against the model; inputs are scrambled while busy.
      for (int i = 0; i < 150; i++) begin
         w   = 1'($urandom_range(0, 1));
         idx = int'($urandom_range(0, DEPTH - 1));
         hi  = $urandom;
         lo  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         a   = (hi << 10) | (32'(idx) << 2) | 32'(lo);
         d   = $urandom;
         er  = ((a % 4) != 0) ? 32'd1 : 32'd0;
         run_and_check("rand", w, a, d, er[0],
                       (er[0] || w) ? 32'h0 : ref_mem[word_of(a)]);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

`ifdef DMEM_STATS_EN
      check("stats_rd", 32'(rd_count), 32'(exp_rd));
      check("stats_wr", 32'(wr_count), 32'(exp_wr));
`endif

      // Zero wait states, req held high across two back-to-back loads.
      bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'h10;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         check($sformatf("b2b_ack_c%0d", c),  32'(bus0.ack),  (c % 2 == 1) ? 32'd1 : 32'd0);
         check($sformatf("b2b_busy_c%0d", c), 32'(bus0.busy), (c % 2 == 1) ? 32'd1 : 32'd0);
         if (c == 3) bus0.req = 1'b0;
      end
`ifdef DMEM_STATS_EN
      check("b2b_stats_rd", 32'(rd_count0), 32'd2);
      check("b2b_stats_wr", 32'(wr_count0), 32'd0);
`endif

      // Zero wait states: store then load of the same word.
      bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 32'h30; bus0.wdata = 32'h600D600D;
      @(posedge clk); #1;
      check("z_store_ack", 32'(bus0.ack), 32'd1);
      bus0.req = 1'b0;
      @(posedge clk); #1;
      bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'h30;
      @(posedge clk); #1;
      check("z_load_ack",   32'(bus0.ack), 32'd1);
      check("z_load_rdata", bus0.rdata,    32'h600D600D);
      bus0.req = 1'b0;
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory slave on the CPU's load/store request channel; it is the responder for the processor core's memory accesses. It accepts one request at a time from the core and holds it with a req/ack handshake. It inserts a programmable number of wait states, then returns read data or commits write data. It allows the core and its controller to be exercised against non-zero memory latency.

Parameters:
DEPTH, 256, number of 32-bit words stored; power of two.
ADDR_W, 8, log2(DEPTH); word-index width.
WAIT_CYCLES, 2, wait states inserted before ack; 0..15.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
req  input  1  request valid; held with addr/we/wdata stable until ack
we  input  1  1 = store (MemWrite), 0 = load (MemRead)
addr  input  32  byte address
wdata  input  32  store data
ack  output  1  one-cycle response pulse
rdata  output  32  load data; valid when ack=1 for a load
err  output  1  misaligned-access flag; valid when ack=1
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, ack=0, err=0, rdata=0, busy=0, wait counter=0. Memory array is not cleared. An in-flight request is aborted and its write is discarded.
- Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- FSM has 3 states: IDLE, WAIT, RESP.
- IDLE:
  - On a clock edge with req=1, latch we/addr/wdata and load counter=WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, otherwise go to RESP.
- WAIT: counter decrements each edge. On the edge where counter==1, go to RESP.
- Entering RESP, the read and error result is registered:
  - Load, aligned: rdata <= mem[index].
  - Misaligned (addr[1:0]!=0): err <= 1, rdata <= 0.
  - Otherwise: err <= 0.
  - Store: rdata holds its previous value.
- RESP lasts one cycle with ack=1.
  - Aligned store: mem[index] <= wdata on the edge leaving RESP.
  - Misaligned store: writes nothing.
  - Next state is always IDLE.
- Latency: if req is first sampled at edge E, ack is high in the cycle following edge E+WAIT_CYCLES. Total latency is WAIT_CYCLES+1 cycles.
- After ack there is always at least one IDLE cycle. req still high in that IDLE cycle is treated as a new request, so the requester must drop req in the cycle after ack if it has nothing further.
- Changes to req/addr/we/wdata while busy=1 are ignored; only latched values are used.
- ack, err and busy are registered outputs, never combinational from req.
- Read-after-write to the same word: the load issued after the store's ack returns the new data.

Optional Feature:
Macro DMEM_STATS_EN.
- Defined: adds output ports rd_count (16) and wr_count (16).
  - Each counts acked aligned loads and aligned stores respectively.
  - Each increments in the cycle after ack, saturates at 16'hFFFF, and resets to 0 on rst.
  - Misaligned accesses are not counted.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then WAIT_CYCLES=2, store addr=0x10 wdata=0xDEADBEEF -> ack high exactly 3 cycles after req sampled, err=0, busy high 2 cycles before ack.
- Load addr=0x10 after that store -> ack 3 cycles later with rdata=0xDEADBEEF, err=0.
- Load addr=0x13 (misaligned) -> ack with err=1, rdata=0; a following load of 0x10 still returns 0xDEADBEEF.
- Store addr=0x410 (DEPTH=256 wraps to index 4) wdata=0x1234, then load 0x10 -> rdata=0x00001234.
- Assert rst=0 during WAIT of a store to 0x20 wdata=0xAAAA5555 -> ack/busy drop immediately; a later load 0x20 returns the prior contents, not 0xAAAA5555.
- WAIT_CYCLES=0, req held high for 2 back-to-back loads -> ack pulses in cycles 1 and 3. With DMEM_STATS_EN defined, rd_count=2 and wr_count=0 afterwards.
